// File: rtl/heartaware_pkg.sv
// Shared types and default ADC0804 timing for the heartaware capture path.
package heartaware_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        READ  = 3'd3,
        DONE  = 3'd4
    } adc_state_e;

    localparam int WR_CYCLES      = 10;
    localparam int RD_CYCLES      = 20;
    localparam int TIMEOUT_CYCLES = 20_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc0804_sampler_tick_gen.sv
// Enable-gated divider producing a one-cycle sample request every DIV cycles.
module sample_tick_gen #(
    parameter int DIV = 10_000_000
) (
    input  logic clk_100mhz,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!enable || cnt == W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == W'(DIV - 1));

endmodule

// File: rtl/synchronize.sv
// Multi-stage flop synchronizer for a single asynchronous level.
module synchronize #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // NOTE: no reset here; the chain flushes itself within STAGES cycles and a
    // reset would only add a path from the reset net into the metastable flop.
    always_ff @(posedge clk) begin
        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/adc0804_sampler.sv
// ADC0804 handshake controller: periodic conversions, validated samples and a
// wrapping write address for the recording memory.
module adc0804_sampler #(
    parameter int SAMPLE_DIV     = 10_000_000,
    parameter int WR_CYCLES      = heartaware_pkg::WR_CYCLES,
    parameter int RD_CYCLES      = heartaware_pkg::RD_CYCLES,
    parameter int TIMEOUT_CYCLES = heartaware_pkg::TIMEOUT_CYCLES,
    parameter int ADDR_W         = 10
) (
    input  logic              clk_100mhz,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [7:0]        adc_data,
    input  logic              adc_intr_n,
    output logic              adc_cs_n,
    output logic              adc_wr_n,
    output logic              adc_rd_n,
    output logic [7:0]        sample,
    output logic              sample_valid,
    output logic [ADDR_W-1:0] sample_addr,
    output logic              buffer_wrapped,
    output logic              timeout_err,
    output logic              overrun,
    output logic [2:0]        state_dbg
);

    import heartaware_pkg::*;

    localparam int CNT_W = $clog2(max3(WR_CYCLES, RD_CYCLES, TIMEOUT_CYCLES) + 1);

    adc_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             intr_sync;
    logic             intr_s;

    sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .clk_100mhz (clk_100mhz),
        .reset_n    (reset_n),
        .enable     (enable),
        .tick       (tick)
    );

    synchronize #(.STAGES(2)) u_intr_sync (
        .clk (clk_100mhz),
        .d   (adc_intr_n),
        .q   (intr_sync)
    );

    assign intr_s    = ~intr_sync;
    assign state_dbg = state;

    // NOTE: every register below uses <= so all of them see the pre-edge values
    // of state/cnt/sample_valid, independent of statement order.
    always_ff @(posedge clk_100mhz) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= '0;
            adc_cs_n       <= 1'b1;
            adc_wr_n       <= 1'b1;
            adc_rd_n       <= 1'b1;
            sample         <= '0;
            sample_valid   <= 1'b0;
            sample_addr    <= '0;
            buffer_wrapped <= 1'b0;
            timeout_err    <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            sample_valid <= 1'b0;

            // A request while busy is dropped, never queued.
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end

            if (sample_valid) begin
                sample_addr <= sample_addr + ADDR_W'(1);
                if (&sample_addr) begin
                    buffer_wrapped <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (tick) begin
                        state    <= START;
                        adc_cs_n <= 1'b0;
                        adc_wr_n <= 1'b0;
                        cnt      <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(WR_CYCLES - 1)) begin
                        state    <= WAIT;
                        adc_wr_n <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    // A stale INTR is fine: the ADC itself clears it on WR.
                    if (intr_s) begin
                        state    <= READ;
                        adc_rd_n <= 1'b0;
                        cnt      <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state       <= IDLE;
                        adc_cs_n    <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                READ: begin
                    if (cnt == CNT_W'(RD_CYCLES - 1)) begin
                        state        <= DONE;
                        sample       <= adc_data;
                        sample_valid <= 1'b1;
                        adc_rd_n     <= 1'b1;
                        adc_cs_n     <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    adc_cs_n <= 1'b1;
                    adc_wr_n <= 1'b1;
                    adc_rd_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
